vga_layer_mixer: RTL and testbench
==================================

Name: vga_layer_mixer

Overview:
Pixel-clock timing source and compositor for the sprite layers.
- Generates the x_pos/y_pos scan coordinates that every layer consumes, and drives the VGA sync outputs.
- Receives each layer's RqFlag/Red/Green/Blue response and resolves priority to produce the final pixel.
- Delays sync and blanking so they stay aligned with the layers' ROM read latency.
- Sits between the layer_* blocks and the board VGA DAC.

Parameters:
H_VIS, 10'd640, visible pixels per line
H_FP, 10'd16, horizontal front porch
H_SW, 10'd96, hsync width
H_BP, 10'd48, horizontal back porch
V_VIS, 10'd480, visible lines per frame
V_FP, 10'd10, vertical front porch
V_SW, 10'd2, vsync width
V_BP, 10'd33, vertical back porch
LAYER_LAT, 1, clocks from x_pos/y_pos change to valid layer RGB/RqFlag (1..4)
BG_RGB, 24'h000000, background colour {R,G,B}

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous reset, active-high
x_pos  output  10  current column, 0..H_VIS+H_FP+H_SW+H_BP-1
y_pos  output  10  current line, 0..V_VIS+V_FP+V_SW+V_BP-1
RqFlag0  input  1  layer 0 (background) pixel request
Red0/Green0/Blue0  input  8 each  layer 0 colour
RqFlag1  input  1  layer 1 (boxes/walls) pixel request
Red1/Green1/Blue1  input  8 each  layer 1 colour
RqFlag2  input  1  layer 2 (man) pixel request
Red2/Green2/Blue2  input  8 each  layer 2 colour
hsync  output  1  horizontal sync, active-low
vsync  output  1  vertical sync, active-low
vga_r/vga_g/vga_b  output  8 each  final pixel colour
frame_start  output  1  one-clock pulse, first visible pixel of a frame leaves the mixer

Behaviour:
- Reset (async, while rst=1): x_pos=0, y_pos=0, hsync=1, vsync=1, vga_r/g/b=0, frame_start=0, all delay-line stages cleared to blank/inactive sync.
- Counters:
  - x_pos increments every clk. At H_TOTAL-1 (800-1 by default) it wraps to 0 and y_pos increments.
  - y_pos wraps from V_TOTAL-1 (525-1) to 0 on the same clk x_pos wraps.
  - x_pos and y_pos are registered outputs.
- Raw timing from current counters:
  - vis = (x_pos<H_VIS)&&(y_pos<V_VIS).
  - hs_n low when H_VIS+H_FP <= x_pos < H_VIS+H_FP+H_SW.
  - vs_n low when V_VIS+V_FP <= y_pos < V_VIS+V_FP+V_SW.
  - first = (x_pos==0)&&(y_pos==0).
- Alignment: vis, hs_n, vs_n and first pass through a LAYER_LAT-deep shift register, so the delayed copies line up with layer responses for the same coordinate.
- Priority select, combinational on the aligned inputs:
  - RqFlag2 → layer 2 colour; else RqFlag1 → layer 1; else RqFlag0 → layer 0; else BG_RGB.
  - If the delayed vis=0, the colour is forced to 0 regardless of RqFlag.
- Output stage: one more register. vga_r/g/b, hsync, vsync and frame_start all update on the same edge.
- Total latency from a coordinate on x_pos/y_pos to its pixel on vga_*: LAYER_LAT+1 clocks. hsync/vsync share the same latency.
- RqFlag inputs outside the visible area are ignored. Multiple simultaneous RqFlags resolve strictly by the priority above.
- rst asserted mid-frame: everything returns to reset values immediately. After release, scan restarts at (0,0) and the first frame_start occurs LAYER_LAT+1 clocks after release.

Optional Feature:
MIXER_FRAME_CNT_EN
- Defined: adds output frame_cnt [15:0]. It resets to 0, increments on each clk where frame_start=1, and wraps at 16'hFFFF→0. Layers use it for animation.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Release rst, run 1 frame → x_pos wraps 799→0, y_pos steps once per line and wraps 524→0; exactly 800*525 clks between frame_start pulses.
- Default params → hsync low for exactly 96 clks starting LAYER_LAT+1 clks after x_pos==656; vsync low for exactly 2 lines starting when y_pos==490, same latency.
- LAYER_LAT=1, all three RqFlags=1 with Red2=8'h12, Red1=8'h34, Red0=8'h56 → vga_r=8'h12. Drop RqFlag2 → 8'h34. Drop RqFlag1 → 8'h56. Drop all → BG_RGB.
- RqFlag2=1 with Red2=8'hFF held during x_pos 640..799 → vga_r=0 for every corresponding output clk.
- Assert rst at x_pos=300,y_pos=200 for 3 clks → outputs snap to reset values asynchronously; after release x_pos counts 0,1,2…; first frame_start after 2 clks.
- MIXER_FRAME_CNT_EN defined, run 3 frames from reset → frame_cnt=3 after the third frame_start.

Source files
------------

// File: rtl/vga_layer_mixer.sv
// VGA scan timing generator and three-layer priority compositor for the sprite layers.
// Define MIXER_FRAME_CNT_EN to add a free-running 16-bit frame_cnt output for layer animation.
module vga_layer_mixer #(
  parameter logic [9:0]  H_VIS     = 10'd640,
  parameter logic [9:0]  H_FP      = 10'd16,
  parameter logic [9:0]  H_SW      = 10'd96,
  parameter logic [9:0]  H_BP      = 10'd48,
  parameter logic [9:0]  V_VIS     = 10'd480,
  parameter logic [9:0]  V_FP      = 10'd10,
  parameter logic [9:0]  V_SW      = 10'd2,
  parameter logic [9:0]  V_BP      = 10'd33,
  parameter int unsigned LAYER_LAT = 1,
  parameter logic [23:0] BG_RGB    = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  input  logic        RqFlag0,
  input  logic [7:0]  Red0,
  input  logic [7:0]  Green0,
  input  logic [7:0]  Blue0,
  input  logic        RqFlag1,
  input  logic [7:0]  Red1,
  input  logic [7:0]  Green1,
  input  logic [7:0]  Blue1,
  input  logic        RqFlag2,
  input  logic [7:0]  Red2,
  input  logic [7:0]  Green2,
  input  logic [7:0]  Blue2,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
`ifdef MIXER_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [9:0] H_TOTAL    = H_VIS + H_FP + H_SW + H_BP;
  localparam logic [9:0] V_TOTAL    = V_VIS + V_FP + V_SW + V_BP;
  localparam logic [9:0] H_SYNC_BEG = H_VIS + H_FP;
  localparam logic [9:0] H_SYNC_END = H_VIS + H_FP + H_SW;
  localparam logic [9:0] V_SYNC_BEG = V_VIS + V_FP;
  localparam logic [9:0] V_SYNC_END = V_VIS + V_FP + V_SW;

  typedef struct packed {
    logic vis;
    logic hs_n;
    logic vs_n;
    logic first;
  } timing_t;

  localparam timing_t TIMING_IDLE = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1, first: 1'b0};

  timing_t     raw;
  timing_t     dly [LAYER_LAT];
  timing_t     aligned;
  logic [23:0] pix;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_pos <= '0;
      y_pos <= '0;
    end else if (x_pos == H_TOTAL - 10'd1) begin
      x_pos <= '0;
      y_pos <= (y_pos == V_TOTAL - 10'd1) ? 10'd0 : y_pos + 10'd1;
    end else begin
      x_pos <= x_pos + 10'd1;
    end
  end

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    raw       = TIMING_IDLE;
    raw.vis   = (x_pos < H_VIS) && (y_pos < V_VIS);
    raw.hs_n  = !((x_pos >= H_SYNC_BEG) && (x_pos < H_SYNC_END));
    raw.vs_n  = !((y_pos >= V_SYNC_BEG) && (y_pos < V_SYNC_END));
    raw.first = (x_pos == 10'd0) && (y_pos == 10'd0);
  end

  // NOTE: the alignment stages are reset, unlike a data RAM, so no stale sync pulse or
  // visible flag leaks out during the first LAYER_LAT clocks after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAYER_LAT; i++) dly[i] <= TIMING_IDLE;
    end else begin
      dly[0] <= raw;
      for (int i = 1; i < LAYER_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign aligned = dly[LAYER_LAT-1];

  // Highest-numbered requesting layer wins; blanking overrides everything.
  always_comb begin
    pix = BG_RGB;
    if (RqFlag2)      pix = {Red2, Green2, Blue2};
    else if (RqFlag1) pix = {Red1, Green1, Blue1};
    else if (RqFlag0) pix = {Red0, Green0, Blue0};
    if (!aligned.vis) pix = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_r       <= pix[23:16];
      vga_g       <= pix[15:8];
      vga_b       <= pix[7:0];
      hsync       <= aligned.hs_n;
      vsync       <= aligned.vs_n;
      frame_start <= aligned.first;
    end
  end

`ifdef MIXER_FRAME_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              frame_cnt <= '0;
    else if (frame_start) frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Scoreboard bench for vga_layer_mixer: a bench-side scan model predicts every output pixel,
// using a shrunken frame geometry so several complete frames fit in a short run.
module tb_vga_layer_mixer;

  localparam int H_VIS = 16, H_FP = 4, H_SW = 6, H_BP = 6;
  localparam int V_VIS = 12, V_FP = 2, V_SW = 2, V_BP = 4;
  localparam int H_TOTAL = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SW + V_BP;
  localparam int FT = H_TOTAL * V_TOTAL;
  localparam int LAT = 1;
  localparam logic [23:0] BG = 24'h203040;

  typedef struct packed {
    logic [2:0]      rq;
    logic [2:0][7:0] r;
    logic [2:0][7:0] g;
    logic [2:0][7:0] b;
  } resp_t;

  typedef struct packed {
    logic        vis;
    logic        hs;
    logic        vs;
    logic        fs;
    logic [23:0] rgb;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] x_pos, y_pos;
  logic RqFlag0 = 0, RqFlag1 = 0, RqFlag2 = 0;
  logic [7:0] Red0 = 0, Green0 = 0, Blue0 = 0;
  logic [7:0] Red1 = 0, Green1 = 0, Blue1 = 0;
  logic [7:0] Red2 = 0, Green2 = 0, Blue2 = 0;
  logic hsync, vsync, frame_start;
  logic [7:0] vga_r, vga_g, vga_b;
`ifdef MIXER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  int exp_fc;
`endif

  int checks = 0;
  int errors = 0;

  int mx, my, cyc;
  int mode = 0;
  logic [2:0] fixed_rq = 3'b000;
  exp_t  exp_q[$];
  resp_t resp_q[$];
  exp_t  last_exp;
  bit    last_valid;
  int last_fs_cyc, fs_period, fs_count;
  int hs_run, hs_last, vs_run, vs_last;

  vga_layer_mixer #(
    .H_VIS(10'(H_VIS)), .H_FP(10'(H_FP)), .H_SW(10'(H_SW)), .H_BP(10'(H_BP)),
    .V_VIS(10'(V_VIS)), .V_FP(10'(V_FP)), .V_SW(10'(V_SW)), .V_BP(10'(V_BP)),
    .LAYER_LAT(LAT), .BG_RGB(BG)
  ) dut (
    .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos),
    .RqFlag0(RqFlag0), .Red0(Red0), .Green0(Green0), .Blue0(Blue0),
    .RqFlag1(RqFlag1), .Red1(Red1), .Green1(Green1), .Blue1(Blue1),
    .RqFlag2(RqFlag2), .Red2(Red2), .Green2(Green2), .Blue2(Blue2),
    .hsync(hsync), .vsync(vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start)
`ifdef MIXER_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Layer behaviour the bench emulates for a given coordinate.
  function automatic resp_t layer_resp(int x, int y);
    resp_t r;
    r = '0;
    case (mode)
      1: begin
        r.rq = 3'(x + 3 * y);
        for (int i = 0; i < 3; i++) begin
          r.r[i] = 8'(x * 7 + i * 50);
          r.g[i] = 8'(y * 5 + i * 30 + 3);
          r.b[i] = 8'(x + y + i * 90);
        end
      end
      2: begin
        r.rq = fixed_rq;
        r.r[2] = 8'h12; r.r[1] = 8'h34; r.r[0] = 8'h56;
        r.g[2] = 8'hA1; r.g[1] = 8'hA2; r.g[0] = 8'hA3;
        r.b[2] = 8'hB1; r.b[1] = 8'hB2; r.b[0] = 8'hB3;
      end
      3: begin
        r.rq = 3'b100;
        r.r[2] = 8'hFF; r.g[2] = 8'hFF; r.b[2] = 8'hFF;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic exp_t expect_pixel(int x, int y, resp_t r);
    exp_t e;
    e.vis = (x < H_VIS) && (y < V_VIS);
    e.hs  = !((x >= H_VIS + H_FP) && (x < H_VIS + H_FP + H_SW));
    e.vs  = !((y >= V_VIS + V_FP) && (y < V_VIS + V_FP + V_SW));
    e.fs  = (x == 0) && (y == 0);
    if (!e.vis)        e.rgb = 24'h0;
    else if (r.rq[2])  e.rgb = {r.r[2], r.g[2], r.b[2]};
    else if (r.rq[1])  e.rgb = {r.r[1], r.g[1], r.b[1]};
    else if (r.rq[0])  e.rgb = {r.r[0], r.g[0], r.b[0]};
    else               e.rgb = BG;
    return e;
  endfunction

  task automatic drive(resp_t r);
    RqFlag0 = r.rq[0]; Red0 = r.r[0]; Green0 = r.g[0]; Blue0 = r.b[0];
    RqFlag1 = r.rq[1]; Red1 = r.r[1]; Green1 = r.g[1]; Blue1 = r.b[1];
    RqFlag2 = r.rq[2]; Red2 = r.r[2]; Green2 = r.g[2]; Blue2 = r.b[2];
  endtask

  // One scan position: check coordinates, feed the layer response due now, retire the oldest prediction.
  task automatic sb_step();
    exp_t e;
    resp_t r;
    checks++;
    if (x_pos !== 10'(mx) || y_pos !== 10'(my)) begin
      errors++;
      $display("FAIL coord cyc=%0d: got x=%0d y=%0d, expected x=%0d y=%0d", cyc, x_pos, y_pos, mx, my);
    end
    r = layer_resp(mx, my);
    exp_q.push_back(expect_pixel(mx, my, r));
    resp_q.push_back(r);
    if (resp_q.size() == LAT + 1) drive(resp_q.pop_front());
    if (exp_q.size() == LAT + 2) begin
      e = exp_q.pop_front();
      checks++;
      if (hsync !== e.hs || vsync !== e.vs || frame_start !== e.fs || {vga_r, vga_g, vga_b} !== e.rgb) begin
        errors++;
        $display("FAIL pixel cyc=%0d: got hs=%b vs=%b fs=%b rgb=%h, expected hs=%b vs=%b fs=%b rgb=%h",
                 cyc, hsync, vsync, frame_start, {vga_r, vga_g, vga_b}, e.hs, e.vs, e.fs, e.rgb);
      end
`ifdef MIXER_FRAME_CNT_EN
      checks++;
      if (frame_cnt !== 16'(exp_fc)) begin
        errors++;
        $display("FAIL frame_cnt cyc=%0d: got %0d, expected %0d", cyc, frame_cnt, exp_fc);
      end
      if (e.fs) exp_fc++;
`endif
      last_exp = e;
      last_valid = 1'b1;
    end
    if (frame_start === 1'b1) begin
      if (last_fs_cyc >= 0) fs_period = cyc - last_fs_cyc;
      last_fs_cyc = cyc;
      fs_count++;
    end
    if (hsync === 1'b0) hs_run++;
    else if (hs_run > 0) begin hs_last = hs_run; hs_run = 0; end
    if (vsync === 1'b0) vs_run++;
    else if (vs_run > 0) begin vs_last = vs_run; vs_run = 0; end
    mx = (mx == H_TOTAL - 1) ? 0 : mx + 1;
    if (mx == 0) my = (my == V_TOTAL - 1) ? 0 : my + 1;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    sb_step();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    resp_q.delete();
    drive('0);
    mx = 0; my = 0; cyc = 0;
    last_valid = 1'b0;
    last_fs_cyc = -1; fs_period = -1; fs_count = 0;
    hs_run = 0; hs_last = -1; vs_run = 0; vs_last = -1;
`ifdef MIXER_FRAME_CNT_EN
    exp_fc = 0;
`endif
    sb_step();
  endtask

  task automatic check_reset_values(string tag);
    checks++;
    if (x_pos !== 10'd0 || y_pos !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1 ||
        {vga_r, vga_g, vga_b} !== 24'h0 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b rgb=%h fs=%b, expected 0 0 1 1 000000 0",
               tag, x_pos, y_pos, hsync, vsync, {vga_r, vga_g, vga_b}, frame_start);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    RqFlag2 = 1'b1; Red2 = 8'hFF; Green2 = 8'hFF; Blue2 = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_state");
    release_reset();
  endtask

  task automatic test_scan();
    mode = 1;
    run(2 * FT + LAT + 5);
    checks++;
    if (hs_last !== H_SW) begin
      errors++;
      $display("FAIL hsync_width: got %0d clks, expected %0d", hs_last, H_SW);
    end
    checks++;
    if (vs_last !== V_SW * H_TOTAL) begin
      errors++;
      $display("FAIL vsync_width: got %0d clks, expected %0d", vs_last, V_SW * H_TOTAL);
    end
    checks++;
    if (fs_period !== FT) begin
      errors++;
      $display("FAIL frame_period: got %0d clks, expected %0d", fs_period, FT);
    end
  endtask

  task automatic test_priority();
    logic [2:0] rq_tab [4];
    logic [7:0] r_tab  [4];
    bit found;
    rq_tab[0] = 3'b111; rq_tab[1] = 3'b011; rq_tab[2] = 3'b001; rq_tab[3] = 3'b000;
    r_tab[0]  = 8'h12;  r_tab[1]  = 8'h34;  r_tab[2]  = 8'h56;  r_tab[3]  = BG[23:16];
    mode = 2;
    for (int k = 0; k < 4; k++) begin
      fixed_rq = rq_tab[k];
      run(FT);
      found = 1'b0;
      for (int i = 0; i < FT && !found; i++) begin
        tick();
        if (last_valid && last_exp.vis) found = 1'b1;
      end
      checks++;
      if (!found) begin
        errors++;
        $display("FAIL priority_%0d: no visible pixel reached within %0d clks", k, FT);
      end else if (vga_r !== r_tab[k]) begin
        errors++;
        $display("FAIL priority_%0d: got vga_r=%h, expected %h", k, vga_r, r_tab[k]);
      end
    end
  endtask

  task automatic test_blanking();
    mode = 3;
    run(LAT + 2);
    for (int i = 0; i < FT; i++) begin
      tick();
      checks++;
      if (!last_exp.vis && {vga_r, vga_g, vga_b} !== 24'h0) begin
        errors++;
        $display("FAIL blanking cyc=%0d: got rgb=%h, expected 000000", cyc, {vga_r, vga_g, vga_b});
      end else if (last_exp.vis && vga_r !== 8'hFF) begin
        errors++;
        $display("FAIL blank_visible cyc=%0d: got vga_r=%h, expected ff", cyc, vga_r);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit hit;
    mode = 1;
    hit = 1'b0;
    for (int i = 0; i < 2 * FT && !hit; i++) begin
      @(posedge clk);
      #1;
      if (mx == 10 && my == 5) hit = 1'b1;
      else sb_step();
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_reset: scan position (10,5) not reached");
    end
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("held_reset");
    release_reset();
    for (int i = 1; i <= LAT + 1; i++) begin
      tick();
      checks++;
      if (x_pos !== 10'(i) || frame_start !== (i == LAT + 1)) begin
        errors++;
        $display("FAIL restart_%0d: got x=%0d fs=%b, expected x=%0d fs=%b",
                 i, x_pos, frame_start, i, (i == LAT + 1));
      end
    end
    run(FT);
  endtask

`ifdef MIXER_FRAME_CNT_EN
  task automatic test_frame_cnt();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    release_reset();
    for (int i = 0; i < 4 * FT && fs_count < 3; i++) tick();
    tick();
    checks++;
    if (fs_count !== 3 || frame_cnt !== 16'd3) begin
      errors++;
      $display("FAIL frame_cnt_3: got frame_cnt=%0d after %0d pulses, expected 3 after 3", frame_cnt, fs_count);
    end
  endtask
`endif

  initial begin
    mx = 0; my = 0; cyc = 0;
    test_reset();
    test_scan();
    test_priority();
    test_blanking();
    test_mid_reset();
`ifdef MIXER_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
